serial_lsu: RTL and testbench

SERIAL_LSU -- requirements
Module: serial_lsu

---
 rtl/serial_lsu_pkg.sv | 22 ++
 rtl/serial_lsu_shreg.sv | 24 ++
 rtl/serial_lsu.sv | 148 ++++++++++++++
 tb/tb_serial_lsu.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_lsu_pkg.sv
// serial_lsu_pkg: RV32 funct3 codes, access-size codes, FSM state enum and digit-count helpers.
package serial_lsu_pkg;
   localparam logic [2:0] F_LB  = 3'b000;
   localparam logic [2:0] F_LH  = 3'b001;
   localparam logic [2:0] F_LW  = 3'b010;
   localparam logic [2:0] F_LBU = 3'b100;
   localparam logic [2:0] F_LHU = 3'b101;
   localparam logic [1:0] SZ_B  = 2'd0;
   localparam logic [1:0] SZ_H  = 2'd1;
   localparam logic [1:0] SZ_W  = 2'd2;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_MEM, S_OUT, S_DONE} state_t;
   function automatic int digit_cnt(input int dw);
      return 32 / dw;
   endfunction
   // any code other than the byte and halfword forms behaves as a word access
   function automatic logic [1:0] f3_size(input logic [2:0] f);
      return (f == F_LB || f == F_LBU) ? SZ_B : (f == F_LH || f == F_LHU) ? SZ_H : SZ_W;
   endfunction
   function automatic logic f3_signed(input logic [2:0] f);
      return f == F_LB || f == F_LH;
   endfunction
endpackage

// File: rtl/serial_lsu_shreg.sv
// serial_lsu_shreg: 32-bit loadable shift register taking DIGIT_W-bit digits in at the top, LSB first.
// Ports: clk, rst_n (async active-low); i_load/i_data parallel load (wins over shift);
// i_shift/i_digit shift one digit in; o_q current value; o_next value after a shift.
module serial_lsu_shreg #(
   parameter int DIGIT_W = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [31:0]        i_data,
   input  logic               i_shift,
   input  logic [DIGIT_W-1:0] i_digit,
   output logic [31:0]        o_q,
   output logic [31:0]        o_next
);
   logic [31:0] r_q;
   assign o_q    = r_q;
   assign o_next = {i_digit, r_q[31:DIGIT_W]};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= '0;
      else if (i_load) r_q <= i_data;
      else if (i_shift) r_q <= o_next;
   end
endmodule

// File: rtl/serial_lsu.sv
// serial_lsu: digit-serial RV32 load/store unit in front of a 32-bit word-addressed memory port.
// Ports: clk, rst_n (async active-low); start/is_store/func begin a transfer; ser_in carries the
// address then store-data digits LSB first; ser_out/ser_valid return load data LSB first;
// busy/done/misaligned report status; mem_req/mem_we/mem_addr/mem_be/mem_wdata with mem_ack/mem_rdata
// form a req/ack memory port.
// Build option SERIAL_LSU_MISALIGN_TRAP_EN: misaligned accesses end with done+misaligned and no
// memory request; otherwise they are aligned down to the access size.
module serial_lsu
   import serial_lsu_pkg::*;
#(
   parameter int DIGIT_W = 1,
   parameter int AW      = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_store,
   input  logic [2:0]         func,
   input  logic [DIGIT_W-1:0] ser_in,
   output logic [DIGIT_W-1:0] ser_out,
   output logic               ser_valid,
   output logic               busy,
   output logic               done,
   output logic               misaligned,
   output logic               mem_req,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [3:0]         mem_be,
   output logic [31:0]        mem_wdata,
   input  logic               mem_ack,
   input  logic [31:0]        mem_rdata
);
   localparam int N  = digit_cnt(DIGIT_W);
   localparam int CW = $clog2(N);
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_store, r_sign, r_ser_valid, r_done, r_mis, r_req, r_we;
   logic [1:0]    r_size, r_off;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_be;
   logic [31:0]   r_wdata;
   logic [31:0]   w_addr_q, w_addr_nx, w_data_q, w_data_nx, w_addr, w_wd, w_lane, w_rd;
   logic [1:0]    w_off;
   logic [3:0]    w_be;
   logic          w_last, w_enter, w_trap, w_load_rd, w_unused;
   assign w_last    = r_cnt == CW'(N - 1);
   assign w_enter   = w_last && (r_state == S_WDATA || (r_state == S_ADDR && !r_store));
   // the last digit is still being shifted on the MEM-entry edge, so decode from the shifter's next value
   assign w_addr    = r_state == S_ADDR ? w_addr_nx : w_addr_q;
   assign w_wd      = r_state == S_WDATA ? w_data_nx : w_data_q;
   assign w_be      = r_size == SZ_B ? 4'b0001 : r_size == SZ_H ? 4'b0011 : 4'b1111;
   assign w_unused  = ^w_addr[31:AW+2];
`ifdef SERIAL_LSU_MISALIGN_TRAP_EN
   assign w_trap    = (r_size == SZ_H && w_addr[0]) || (r_size == SZ_W && w_addr[1:0] != 2'b00);
   assign w_off     = w_addr[1:0];
`else
   assign w_trap    = 1'b0;
   assign w_off     = r_size == SZ_W ? 2'b00 : r_size == SZ_H ? {w_addr[1], 1'b0} : w_addr[1:0];
`endif
   assign w_lane    = mem_rdata >> {r_off, 3'b000};
   assign w_rd      = r_size == SZ_B ? {{24{r_sign & w_lane[7]}}, w_lane[7:0]} :
                      r_size == SZ_H ? {{16{r_sign & w_lane[15]}}, w_lane[15:0]} : w_lane;
   assign w_load_rd = r_state == S_MEM && mem_ack && !r_we;
   assign ser_out    = w_data_q[DIGIT_W-1:0];
   assign ser_valid  = r_ser_valid;
   assign busy       = r_state != S_IDLE;
   assign done       = r_done;
   assign misaligned = r_mis;
   assign mem_req    = r_req;
   assign mem_we     = r_we;
   assign mem_addr   = r_addr;
   assign mem_be     = r_be;
   assign mem_wdata  = r_wdata;
   serial_lsu_shreg #(.DIGIT_W(DIGIT_W)) u_addr (
      .clk(clk), .rst_n(rst_n), .i_load(1'b0), .i_data(32'd0), .i_shift(r_state == S_ADDR),
      .i_digit(ser_in), .o_q(w_addr_q), .o_next(w_addr_nx)
   );
   // carries store data in, then the extended load result out
   serial_lsu_shreg #(.DIGIT_W(DIGIT_W)) u_data (
      .clk(clk), .rst_n(rst_n), .i_load(w_load_rd), .i_data(w_rd),
      .i_shift(r_state == S_WDATA || r_state == S_OUT), .i_digit(ser_in), .o_q(w_data_q), .o_next(w_data_nx)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_store     <= 1'b0;
         r_sign      <= 1'b0;
         r_size      <= SZ_B;
         r_off       <= 2'b00;
         r_ser_valid <= 1'b0;
         r_done      <= 1'b0;
         r_mis       <= 1'b0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_be        <= 4'b0000;
         r_wdata     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_store <= is_store;
               r_size  <= f3_size(func);
               r_sign  <= f3_signed(func);
               r_cnt   <= '0;
               r_state <= S_ADDR;
            end
            S_ADDR: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last) r_state <= S_WDATA;
            end
            S_WDATA: r_cnt <= r_cnt + 1'b1;
            S_MEM: if (mem_ack) begin
               r_req       <= 1'b0;
               r_we        <= 1'b0;
               r_ser_valid <= !r_we;
               r_done      <= r_we;
               r_state     <= r_we ? S_DONE : S_OUT;
            end
            S_OUT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_ser_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            default: begin
               r_mis   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
         // overrides the ADDR/WDATA next-state choice when the final digit arrives
         if (w_enter) begin
            r_state <= w_trap ? S_DONE : S_MEM;
            r_done  <= w_trap;
            r_mis   <= w_trap;
            r_req   <= !w_trap;
            r_we    <= !w_trap && r_store;
            r_addr  <= w_addr[AW+1:2];
            r_be    <= r_store ? w_be << w_off : 4'hF;
            r_wdata <= r_store ? w_wd << {w_off, 3'b000} : '0;
            r_off   <= w_off;
         end
      end
   end
endmodule

// File: tb/tb_serial_lsu.sv
// tb_serial_lsu: randomized self-checking bench for serial_lsu at DIGIT_W=1 and DIGIT_W=4.
// Honours SERIAL_LSU_MISALIGN_TRAP_EN in its reference model.
module tb_serial_lsu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0, start4 = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
   logic [2:0]  func = 3'd0;
   logic [0:0]  ser_in1 = 1'b0;
   logic [3:0]  ser_in4 = 4'd0;
   logic [31:0] mem_rdata = 32'd0;
   logic [0:0]  so1;
   logic [3:0]  so4;
   logic        sv1, sv4, busy1, busy4, done1, done4, mis1, mis4, req1, req4, we1, we4;
   logic [9:0]  addr1, addr4;
   logic [3:0]  be1, be4;
   logic [31:0] wd1, wd4;
   bit          sel = 1'b0;
   int          vectors = 0, errors = 0;
   logic [3:0]  s_so, s_be;
   logic        s_sv, s_busy, s_done, s_mis, s_req, s_we;
   logic [9:0]  s_addr;
   logic [31:0] s_wd;
   int          ob_lat, ob_req_cyc, ob_vcnt;
   bit          ob_done, ob_stable, ob_vmem, ob_mis, ob_tail;
   logic [31:0] ob_stream, ob_wd;
   logic [9:0]  ob_addr;
   logic [3:0]  ob_be;
   logic        ob_we;

   always #5 clk = ~clk;

   serial_lsu #(.DIGIT_W(1), .AW(10)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .is_store(is_store), .func(func), .ser_in(ser_in1),
      .ser_out(so1), .ser_valid(sv1), .busy(busy1), .done(done1), .misaligned(mis1), .mem_req(req1),
      .mem_we(we1), .mem_addr(addr1), .mem_be(be1), .mem_wdata(wd1), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );
   serial_lsu #(.DIGIT_W(4), .AW(10)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .is_store(is_store), .func(func), .ser_in(ser_in4),
      .ser_out(so4), .ser_valid(sv4), .busy(busy4), .done(done4), .misaligned(mis4), .mem_req(req4),
      .mem_we(we4), .mem_addr(addr4), .mem_be(be4), .mem_wdata(wd4), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   assign s_so   = sel ? so4 : {3'b000, so1};
   assign s_sv   = sel ? sv4 : sv1;
   assign s_busy = sel ? busy4 : busy1;
   assign s_done = sel ? done4 : done1;
   assign s_mis  = sel ? mis4 : mis1;
   assign s_req  = sel ? req4 : req1;
   assign s_we   = sel ? we4 : we1;
   assign s_addr = sel ? addr4 : addr1;
   assign s_be   = sel ? be4 : be1;
   assign s_wd   = sel ? wd4 : wd1;

   // reference: byte-address arithmetic on access size and offset
   function automatic void model(input bit st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] rd, output logic [9:0] ea, output logic [3:0] eb,
                                 output logic [31:0] ew, output logic [31:0] er, output bit em);
      int sz, off, u;
      logic [31:0] lane;
      sz = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
      off = int'(a % 4);
      em = off % sz != 0;
`ifndef SERIAL_LSU_MISALIGN_TRAP_EN
      off = off - off % sz;
      em = 1'b0;
`endif
      ea = 10'((a / 4) % 1024);
      eb = st ? 4'(((1 << sz) - 1) << off) : 4'hF;
      ew = d << (8 * off);
      lane = rd >> (8 * off);
      if (sz == 4) er = lane;
      else begin
         u = sz == 1 ? int'(lane % 256) : int'(lane % 65536);
         if (f == 3'd0 && u >= 128) u = u - 256;
         if (f == 3'd1 && u >= 32768) u = u - 65536;
         er = 32'(u);
      end
   endfunction

   task automatic xfer(input bit w, input bit st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int dly);
      int n, dw;
      logic [31:0] dig;
      sel = w;
      n = w ? 8 : 32;
      dw = w ? 4 : 1;
      ob_lat = 0; ob_req_cyc = 0; ob_vcnt = 0; ob_done = 0; ob_stable = 1; ob_vmem = 0; ob_mis = 0;
      ob_tail = 0; ob_stream = 0; ob_addr = 0; ob_be = 0; ob_wd = 0; ob_we = 0;
      @(negedge clk);
      is_store = st;
      func = f;
      mem_rdata = rd;
      if (w) start4 = 1'b1; else start1 = 1'b1;
      for (int k = 0; k < 400 && !ob_done; k++) begin
         @(negedge clk);
         ob_lat++;
         start1 = 1'b0;
         start4 = 1'b0;
         if (s_done) begin
            ob_done = 1;
            ob_mis = s_mis;
         end
         if (s_req) begin
            ob_req_cyc++;
            if (ob_req_cyc == 1) begin
               ob_addr = s_addr; ob_be = s_be; ob_wd = s_wd; ob_we = s_we;
            end else if ({s_addr, s_be, s_wd, s_we} !== {ob_addr, ob_be, ob_wd, ob_we}) ob_stable = 0;
            if (s_sv) ob_vmem = 1;
         end
         mem_ack = s_req && ob_req_cyc == dly + 1;
         if (s_sv) begin
            ob_stream = ob_stream | (32'(s_so) << (ob_vcnt * dw));
            ob_vcnt++;
         end
         dig = k < n ? a >> (k * dw) : (st && k < 2 * n) ? d >> ((k - n) * dw) : 32'd0;
         ser_in1 = dig[0];
         ser_in4 = dig[3:0];
      end
      mem_ack = 1'b0;
      if (!ob_done) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         @(negedge clk);
         ob_tail = s_done | s_busy;
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      vectors++;
      if ({so1, sv1, busy1, done1, mis1, req1, we1, addr1, be1, wd1} !== '0)
         begin errors++; $display("FAIL reset_dw1: got %h want 0", {so1, sv1, busy1, done1, mis1, req1, we1, addr1, be1, wd1}); end
      vectors++;
      if ({so4, sv4, busy4, done4, mis4, req4, we4, addr4, be4, wd4} !== '0)
         begin errors++; $display("FAIL reset_dw4: got %h want 0", {so4, sv4, busy4, done4, mis4, req4, we4, addr4, be4, wd4}); end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy1, busy4} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: busy %b want 00", {busy1, busy4}); end
   endtask

   task automatic test_lb_dw1;
      xfer(1'b0, 1'b0, 3'b000, 32'h003, 32'd0, 32'h80FF1234, 0);
      vectors++; if (ob_done !== 1'b1) begin errors++; $display("FAIL lb_done: got %b want 1", ob_done); end
      vectors++; if (ob_stream !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_stream: got %h want ffffff80", ob_stream); end
      vectors++; if (ob_addr !== 10'd0) begin errors++; $display("FAIL lb_addr: got %h want 0", ob_addr); end
      vectors++; if (ob_lat !== 66) begin errors++; $display("FAIL lb_latency: got %0d want 66", ob_lat); end
      vectors++; if (ob_vcnt !== 32) begin errors++; $display("FAIL lb_digits: got %0d want 32", ob_vcnt); end
      vectors++; if ({ob_we, ob_be} !== 5'b01111) begin errors++; $display("FAIL lb_we_be: got %b want 01111", {ob_we, ob_be}); end
      vectors++; if (ob_tail !== 1'b0) begin errors++; $display("FAIL lb_done_pulse: got %b want 0", ob_tail); end
   endtask

   task automatic test_lbu_dw4;
      xfer(1'b1, 1'b0, 3'b100, 32'h003, 32'd0, 32'h80FF1234, 0);
      vectors++; if (ob_stream !== 32'h00000080) begin errors++; $display("FAIL lbu_stream: got %h want 00000080", ob_stream); end
      vectors++; if (ob_vcnt !== 8) begin errors++; $display("FAIL lbu_digits: got %0d want 8", ob_vcnt); end
      vectors++; if (ob_lat !== 18) begin errors++; $display("FAIL lbu_latency: got %0d want 18", ob_lat); end
   endtask

   task automatic test_sh;
      xfer(1'b0, 1'b1, 3'b001, 32'h006, 32'h0000ABCD, 32'd0, 0);
      vectors++; if (ob_addr !== 10'd1) begin errors++; $display("FAIL sh_addr: got %h want 1", ob_addr); end
      vectors++; if (ob_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", ob_be); end
      vectors++; if (ob_wd !== 32'hABCD0000) begin errors++; $display("FAIL sh_wdata: got %h want abcd0000", ob_wd); end
      vectors++; if (ob_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", ob_we); end
      vectors++; if (ob_vcnt !== 0) begin errors++; $display("FAIL sh_no_valid: got %0d want 0", ob_vcnt); end
      vectors++; if (ob_lat !== 66) begin errors++; $display("FAIL sh_latency: got %0d want 66", ob_lat); end
   endtask

   task automatic test_lw_misaligned;
      logic [31:0] rd;
      rd = $urandom;
      xfer(1'b0, 1'b0, 3'b010, 32'h002, 32'd0, rd, 0);
`ifdef SERIAL_LSU_MISALIGN_TRAP_EN
      vectors++; if ({ob_done, ob_mis} !== 2'b11) begin errors++; $display("FAIL lw_trap: done,mis %b want 11", {ob_done, ob_mis}); end
      vectors++; if (ob_req_cyc !== 0) begin errors++; $display("FAIL lw_trap_noreq: got %0d req cycles want 0", ob_req_cyc); end
      vectors++; if (ob_lat !== 33) begin errors++; $display("FAIL lw_trap_latency: got %0d want 33", ob_lat); end
`else
      vectors++; if (ob_addr !== 10'd0) begin errors++; $display("FAIL lw_align_addr: got %h want 0", ob_addr); end
      vectors++; if (ob_stream !== rd) begin errors++; $display("FAIL lw_align_stream: got %h want %h", ob_stream, rd); end
      vectors++; if ({ob_done, ob_mis} !== 2'b10) begin errors++; $display("FAIL lw_align_mis: done,mis %b want 10", {ob_done, ob_mis}); end
`endif
   endtask

   task automatic test_ack_delay;
      logic [31:0] rd, er, ew;
      logic [9:0]  ea;
      logic [3:0]  eb;
      bit          em;
      rd = $urandom;
      model(1'b0, 3'b001, 32'h00A, 32'd0, rd, ea, eb, ew, er, em);
      xfer(1'b1, 1'b0, 3'b001, 32'h00A, 32'd0, rd, 3);
      vectors++; if (ob_req_cyc !== 4) begin errors++; $display("FAIL delay_req_cycles: got %0d want 4", ob_req_cyc); end
      vectors++; if (ob_stable !== 1'b1) begin errors++; $display("FAIL delay_stable: got %b want 1", ob_stable); end
      vectors++; if (ob_vmem !== 1'b0) begin errors++; $display("FAIL delay_valid_in_mem: got %b want 0", ob_vmem); end
      vectors++; if (ob_lat !== 21) begin errors++; $display("FAIL delay_latency: got %0d want 21", ob_lat); end
      vectors++; if (ob_stream !== er) begin errors++; $display("FAIL delay_stream: got %h want %h", ob_stream, er); end
   endtask

   task automatic test_reset_mid;
      bit seen;
      sel = 1'b0;
      @(negedge clk);
      is_store = 1'b0;
      func = 3'b010;
      start1 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start1 = 1'b0;
         ser_in1 = 1'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({so1, sv1, busy1, done1, mis1, req1, we1, addr1, be1, wd1} !== '0)
         begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", {so1, sv1, busy1, done1, mis1, req1, we1, addr1, be1, wd1}); end
      seen = done1;
      repeat (2) begin
         @(negedge clk);
         seen = seen | done1;
      end
      start1 = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      seen = seen | done1;
      vectors++; if (busy1 !== 1'b1) begin errors++; $display("FAIL mid_reset_accept: busy %b want 1", busy1); end
      vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done: got %b want 0", seen); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random;
      bit          w, st, em;
      logic [2:0]  f;
      logic [31:0] a, d, rd, ew, er;
      logic [9:0]  ea;
      logic [3:0]  eb;
      int          dly, n, elat;
      for (int i = 0; i < 30; i++) begin
         w = 1'($urandom);
         st = 1'($urandom);
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         d = $urandom;
         rd = $urandom;
         dly = $urandom_range(0, 3);
         n = w ? 8 : 32;
         model(st, f, a, d, rd, ea, eb, ew, er, em);
         elat = em ? (st ? 2 * n + 1 : n + 1) : 2 * n + dly + 2;
         xfer(w, st, f, a, d, rd, dly);
         vectors++; if ({ob_done, ob_mis} !== {1'b1, em}) begin errors++; $display("FAIL rnd%0d_done_mis: got %b want %b", i, {ob_done, ob_mis}, {1'b1, em}); end
         vectors++; if (ob_lat !== elat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, ob_lat, elat); end
         vectors++; if (ob_req_cyc !== (em ? 0 : dly + 1)) begin errors++; $display("FAIL rnd%0d_req_cycles: got %0d want %0d", i, ob_req_cyc, em ? 0 : dly + 1); end
         if (!em) begin
            vectors++; if ({ob_addr, ob_be, ob_we} !== {ea, eb, st}) begin errors++; $display("FAIL rnd%0d_req: got %h want %h", i, {ob_addr, ob_be, ob_we}, {ea, eb, st}); end
            vectors++; if (ob_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable: got %b want 1", i, ob_stable); end
            if (st) begin
               vectors++; if (ob_wd !== ew) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", i, ob_wd, ew); end
            end else begin
               vectors++; if (ob_stream !== er) begin errors++; $display("FAIL rnd%0d_stream: got %h want %h", i, ob_stream, er); end
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_lb_dw1;
      test_lbu_dw4;
      test_sh;
      test_lw_misaligned;
      test_ack_delay;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
